// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access controller.
// Issues a req/ack access to a variable-latency data memory, stalls the
// upstream pipeline while the access is in flight, aligns and extends load
// data, and keeps a sticky error flag for timeouts.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned half/word
// accesses in IDLE (MemError set, no memory request issued).
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              MemReadIn,
  input  logic              MemWriteIn,
  input  logic [1:0]        bytes2LoadIn,
  input  logic [1:0]        bytes2StoreIn,
  input  logic              LoadSignedIn,
  input  logic [ADDR_W-1:0] AddrIn,
  input  logic [31:0]       WriteDataIn,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       LoadDataOut,
  output logic              Stall,
  output logic              MemError
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q;
  logic                mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [3:0]          mem_be_q;
  logic [31:0]         mem_wdata_q;
  logic [31:0]         load_data_q;
  logic                mem_error_q;
  // Load attributes latched at issue so extraction does not depend on EX/MEM
  logic                is_load_q;
  logic [1:0]          ld_size_q;
  logic [1:0]          lane_q;
  logic                ld_signed_q;

  logic                req;
  logic [1:0]          acc_size;
  logic [3:0]          be_d;
  logic [31:0]         wdata_d;
  logic                misalign;
  logic                at_limit;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         load_ext;

  // Request decode: lane enables, replicated store data, alignment check
  always_comb begin
    req      = MemReadIn | MemWriteIn;
    acc_size = MemWriteIn ? bytes2StoreIn : bytes2LoadIn;
    be_d     = 4'b1111;
    wdata_d  = WriteDataIn;
    case (acc_size)
      2'b10: begin
        be_d    = 4'b0001 << AddrIn[1:0];
        wdata_d = {4{WriteDataIn[7:0]}};
      end
      2'b01: begin
        be_d    = AddrIn[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{WriteDataIn[15:0]}};
      end
      default: ;
    endcase
`ifdef MEM_ALIGN_CHECK_EN
    misalign = ((acc_size == 2'b01) && AddrIn[0]) ||
               (((acc_size == 2'b00) || (acc_size == 2'b11)) && (AddrIn[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
  end

  // Lane select and extension of the returning read data
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (lane_q)
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      2'd3:    ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_size_q)
      2'b10:   load_ext = {{24{ld_signed_q & ld_byte[7]}}, ld_byte};
      2'b01:   load_ext = {{16{ld_signed_q & ld_half[15]}}, ld_half};
      default: load_ext = mem_rdata;
    endcase
  end

  assign at_limit = (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge Clk) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req) state_d = misalign ? DONE : WAIT;
      WAIT: if (mem_ack || at_limit) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stall covers the issuing IDLE cycle and every WAIT cycle
  always_comb begin
    Stall = ((state_q == IDLE) && req) || (state_q == WAIT);
  end

  // Memory interface, timeout counter, load result and sticky error
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      load_data_q <= '0;
      mem_error_q <= 1'b0;
      is_load_q   <= 1'b0;
      ld_size_q   <= '0;
      lane_q      <= '0;
      ld_signed_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && misalign) begin
            mem_error_q <= 1'b1;
            load_data_q <= '0;
          end else if (req) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= MemWriteIn;
            mem_addr_q  <= {AddrIn[ADDR_W-1:2], 2'b00};
            mem_be_q    <= be_d;
            mem_wdata_q <= wdata_d;
            cnt_q       <= '0;
            is_load_q   <= MemReadIn & ~MemWriteIn;
            ld_size_q   <= bytes2LoadIn;
            lane_q      <= AddrIn[1:0];
            ld_signed_q <= LoadSignedIn;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            mem_req_q   <= 1'b0;
            load_data_q <= is_load_q ? load_ext : '0;
          end else if (at_limit) begin
            mem_req_q   <= 1'b0;
            mem_error_q <= 1'b1;
            load_data_q <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;
  assign LoadDataOut = load_data_q;
  assign MemError    = mem_error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by
// randomized accesses checked against a behavioural reference model.
module tb_mem_access_unit;

  localparam int unsigned T = 6;

  logic        Clk;
  logic        Rst_n;
  logic        MemReadIn, MemWriteIn;
  logic [1:0]  bytes2LoadIn, bytes2StoreIn;
  logic        LoadSignedIn;
  logic [31:0] AddrIn, WriteDataIn;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [31:0] LoadDataOut;
  logic        Stall, MemError;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_ld;
  logic        exp_err;

  mem_access_unit #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
    .bytes2LoadIn(bytes2LoadIn), .bytes2StoreIn(bytes2StoreIn),
    .LoadSignedIn(LoadSignedIn), .AddrIn(AddrIn), .WriteDataIn(WriteDataIn),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .LoadDataOut(LoadDataOut), .Stall(Stall), .MemError(MemError)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model pieces
  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] a);
    if (sz == 2'b10) return 4'(1 << int'(a));
    if (sz == 2'b01) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b10) return {24'b0, wd[7:0]} * 32'h0101_0101;
    if (sz == 2'b01) return {16'b0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [1:0] a,
                                             input logic sgn, input logic [31:0] d);
    int unsigned sh;
    logic [31:0] mask, v;
    if (sz == 2'b10) begin
      sh = int'(a) * 8;
      mask = 32'hFF;
    end else if (sz == 2'b01) begin
      sh = int'(a[1]) * 16;
      mask = 32'hFFFF;
    end else begin
      return d;
    end
    v = (d >> sh) & mask;
    if (sgn && ((v & ((mask >> 1) + 1)) != 0)) v = v | ~mask;
    return v;
  endfunction

  // One complete access from IDLE through DONE and back to IDLE.
  // ack_lat: WAIT cycle index on which mem_ack pulses; >= T means no ack.
  task automatic do_access(input logic rd, input logic wr, input logic [1:0] lsz,
                           input logic [1:0] ssz, input logic sgn, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdat, input int ack_lat);
    logic [1:0] sz;
    logic       is_rd, acked, mis;
    int         wait_len, stall_seen;
    sz    = wr ? ssz : lsz;
    is_rd = rd & ~wr;
    mis   = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = ((sz == 2'b01) && addr[0]) ||
          (((sz == 2'b00) || (sz == 2'b11)) && (addr[1:0] != 2'b00));
`endif
    acked    = (ack_lat >= 0) && (ack_lat < int'(T));
    wait_len = mis ? 0 : (acked ? ack_lat + 1 : int'(T));

    MemReadIn = rd; MemWriteIn = wr; bytes2LoadIn = lsz; bytes2StoreIn = ssz;
    LoadSignedIn = sgn; AddrIn = addr; WriteDataIn = wd; mem_ack = 1'b0;
    stall_seen = 0;
    #1;
    if (Stall) stall_seen++;
    check_eq("idle_req_low", mem_req, 0);
    @(posedge Clk); #2;
    for (int k = 0; k < wait_len; k++) begin
      if (Stall) stall_seen++;
      check_eq("wait_req", mem_req, 1);
      if (k == 0) begin
        check_eq("wait_we", mem_we, wr);
        check_eq("wait_addr", mem_addr, addr & 32'hFFFF_FFFC);
        check_eq("wait_be", mem_be, model_be(sz, addr[1:0]));
        if (wr) check_eq("wait_wdata", mem_wdata, model_wdata(sz, wd));
      end
      if (acked && k == ack_lat) begin
        mem_ack = 1'b1; mem_rdata = rdat;
      end else begin
        mem_ack = 1'b0; mem_rdata = $urandom;
      end
      @(posedge Clk); #2;
      mem_ack = 1'b0;
    end
    if (Stall) stall_seen++;
    if (mis || !acked) exp_err = 1'b1;
    exp_ld = (acked && is_rd && !mis) ? model_load(lsz, addr[1:0], sgn, rdat) : 32'h0;
    check_eq("done_req", mem_req, 0);
    check_eq("done_load", LoadDataOut, exp_ld);
    check_eq("done_err", MemError, exp_err);
    check_eq("stall_cycles", stall_seen, 1 + wait_len);
    // Pipeline advances; a stray ack in DONE must have no effect
    MemReadIn = 1'b0; MemWriteIn = 1'b0; mem_ack = 1'b1; mem_rdata = $urandom;
    @(posedge Clk); #2;
    mem_ack = 1'b0;
    check_eq("idle_load_hold", LoadDataOut, exp_ld);
    check_eq("idle_req", mem_req, 0);
    check_eq("idle_stall", Stall, 0);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    @(posedge Clk); #2;
    Rst_n = 1'b1;
    exp_ld = '0; exp_err = 1'b0;
    check_eq("rst_req", mem_req, 0);
    check_eq("rst_we", mem_we, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_be", mem_be, 0);
    check_eq("rst_wdata", mem_wdata, 0);
    check_eq("rst_load", LoadDataOut, 0);
    check_eq("rst_err", MemError, 0);
    check_eq("rst_stall", Stall, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rd, wr;
    Rst_n = 1'b0; MemReadIn = 0; MemWriteIn = 0; bytes2LoadIn = 0; bytes2StoreIn = 0;
    LoadSignedIn = 0; AddrIn = 0; WriteDataIn = 0; mem_rdata = 0; mem_ack = 0;
    exp_ld = '0; exp_err = 1'b0;
    repeat (2) @(posedge Clk);
    #2;
    do_reset();

    // Word load, immediate ack
    do_access(1, 0, 2'b00, 2'b00, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    // Signed and unsigned byte loads from lane 3
    do_access(1, 0, 2'b10, 2'b00, 1, 32'h13, 32'h0, 32'h80AA_BBCC, 1);
    do_access(1, 0, 2'b10, 2'b00, 0, 32'h13, 32'h0, 32'h80AA_BBCC, 0);
    // Half store, upper half, ack on the fifth WAIT cycle
    do_access(0, 1, 2'b00, 2'b01, 0, 32'h22, 32'h1234ABCD, 32'h0, 4);
    // Read and write together is a write
    do_access(1, 1, 2'b00, 2'b00, 0, 32'h40, 32'h5555AAAA, 32'h12345678, 0);
    // Misaligned word load (normal access unless alignment checking is built in)
    do_access(1, 0, 2'b00, 2'b00, 0, 32'h02, 32'h0, 32'hCAFEF00D, 0);
    // Timeout, then a good access keeps the sticky error
    do_access(1, 0, 2'b00, 2'b00, 0, 32'h80, 32'h0, 32'h0, int'(T));
    do_access(1, 0, 2'b01, 2'b00, 1, 32'h86, 32'h0, 32'h8001_7FFF, 2);

    // Reset while in WAIT, then a late ack
    MemReadIn = 1; MemWriteIn = 0; bytes2LoadIn = 2'b00; AddrIn = 32'h100;
    @(posedge Clk); #2;
    check_eq("pre_rst_wait_req", mem_req, 1);
    MemReadIn = 0;
    do_reset();
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge Clk); #2;
    mem_ack = 1'b0;
    check_eq("late_ack_req", mem_req, 0);
    check_eq("late_ack_load", LoadDataOut, 0);
    check_eq("late_ack_stall", Stall, 0);

    // Randomized accesses
    for (int i = 0; i < 80; i++) begin
      if (i % 20 == 19) do_reset();
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      do_access(rd, wr, 2'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                $urandom, int'($urandom_range(0, T + 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
